// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage -- instruction fetch stage with a one-entry skid buffer.
//
// Purpose:
//   Issues word-aligned fetch requests to instruction memory, registers the
//   returned word into the IF/ID register that feeds decode, and absorbs a
//   decode stall that coincides with a completed fetch in a one-entry skid
//   buffer, so no instruction is dropped or duplicated. A redirect from
//   execute squashes fetch and restarts at the redirect target.
//
// Ports:
//   clk_i         in   1   clock, all state updates on rising edge
//   rst_i         in   1   synchronous active-high reset
//   stall_i       in   1   decode cannot accept; hold IF/ID
//   redirect_i    in   1   taken branch/jump/ret; squash fetch
//   redirectPC_i  in  32   redirect target (low two bits ignored)
//   imemReq_o     out  1   fetch request valid
//   imemAddr_o    out 32   fetch address, word aligned
//   imemReady_i   in   1   memory accepts; imemRdata_i valid same cycle
//   imemRdata_i   in  32   fetched instruction word
//   valid_o       out  1   IF/ID holds a real instruction
//   rs1_o/rs2_o/rd_o out 5 instr[19:15] / [24:20] / [11:7]
//   Instr31_7_o   out 25   instr[31:7]
//   op_o          out  7   instr[6:0]
//   funct3_o      out  3   instr[14:12]
//   PC_o          out 32   address of the held instruction
//   pcPlus4_o     out 32   PC_o + 4 (modulo 2^32)
// ---------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirectPC_i,
    output logic        imemReq_o,
    output logic [31:0] imemAddr_o,
    input  logic        imemReady_i,
    input  logic [31:0] imemRdata_i,
    output logic        valid_o,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output logic [4:0]  rd_o,
    output logic [24:0] Instr31_7_o,
    output logic [6:0]  op_o,
    output logic [2:0]  funct3_o,
    output logic [31:0] PC_o,
    output logic [31:0] pcPlus4_o
);

    // Canonical NOP (addi x0, x0, 0) used to fill IF/ID with a bubble.
    localparam logic [31:0] NopInstr   = 32'h0000_0013;
    localparam logic [31:0] AlignMask  = 32'hFFFF_FFFC;
    localparam logic [31:0] ResetAlign = RESET_PC & AlignMask;

    typedef enum logic [0:0] {
        StFetch,
        StBuffered
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;

    // Skid buffer: holds one fetched word when decode stalls on completion.
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        skid_full_q, skid_full_d;

    // IF/ID register.
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;

    logic        fetch_req;
    logic        fetch_done;
    logic [31:0] pc_plus4;
    logic [31:0] redirect_target;

    // Requests only go out in FETCH; reset suppresses the request outright.
    assign fetch_req       = (state_q == StFetch) && !rst_i;
    assign fetch_done      = fetch_req && imemReady_i;
    assign pc_plus4        = pc_q + 32'd4;
    assign redirect_target = redirectPC_i & AlignMask;

    assign imemReq_o  = fetch_req;
    assign imemAddr_o = pc_q;

    // Next-state logic. Reset is applied in the register process.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_full_d  = skid_full_q;
        ifid_valid_d = ifid_valid_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;

        if (redirect_i) begin
            // Redirect wins over stall and any same-cycle response.
            state_d      = StFetch;
            pc_d         = redirect_target;
            skid_full_d  = 1'b0;
            ifid_valid_d = 1'b0;
            ifid_instr_d = NopInstr;
            ifid_pc_d    = 32'd0;
        end else begin
            unique case (state_q)
                StFetch: begin
                    if (fetch_done) begin
                        pc_d = pc_plus4;
                        if (stall_i) begin
                            // Decode is busy: park the word, stop requesting.
                            skid_instr_d = imemRdata_i;
                            skid_pc_d    = pc_q;
                            skid_full_d  = 1'b1;
                            state_d      = StBuffered;
                        end else begin
                            ifid_valid_d = 1'b1;
                            ifid_instr_d = imemRdata_i;
                            ifid_pc_d    = pc_q;
                        end
                    end else if (!stall_i) begin
                        // Nothing arrived and decode wants something: bubble.
                        ifid_valid_d = 1'b0;
                        ifid_instr_d = NopInstr;
                        ifid_pc_d    = 32'd0;
                    end
                end
                StBuffered: begin
                    if (!stall_i && skid_full_q) begin
                        ifid_valid_d = 1'b1;
                        ifid_instr_d = skid_instr_q;
                        ifid_pc_d    = skid_pc_q;
                        skid_full_d  = 1'b0;
                        state_d      = StFetch;
                    end
                end
                default: begin
                    state_d = StFetch;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StFetch;
            pc_q         <= ResetAlign;
            skid_instr_q <= NopInstr;
            skid_pc_q    <= 32'd0;
            skid_full_q  <= 1'b0;
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= NopInstr;
            ifid_pc_q    <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_full_q  <= skid_full_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
        end
    end

    // Decode-facing field split of the held instruction.
    assign valid_o     = ifid_valid_q;
    assign op_o        = ifid_instr_q[6:0];
    assign rd_o        = ifid_instr_q[11:7];
    assign funct3_o    = ifid_instr_q[14:12];
    assign rs1_o       = ifid_instr_q[19:15];
    assign rs2_o       = ifid_instr_q[24:20];
    assign Instr31_7_o = ifid_instr_q[31:7];
    assign PC_o        = ifid_pc_q;
    assign pcPlus4_o   = ifid_pc_q + 32'd4;

endmodule
